// File: rtl/conv_1x1_pass_scheduler.sv
// conv_1x1_pass_scheduler
//
// Sequences a 1x1 convolution as one pass per output channel. Each pass
// first streams that channel's CHANNEL_NUM_IN weights out of weight memory
// into the conv core. It then enables the pixel loop for
// IMAGE_SIZE*CHANNEL_NUM_IN accepted pixel beats. Finally it waits until the
// channel adder has produced IMAGE_SIZE results.
//
// Ports
//   clk              rising-edge clock for all state
//   reset            synchronous, active-high
//   start            run request, honoured only while idle
//   weight_rd_en     weight memory read strobe
//   weight_addr      weight memory address (out_ch*CHANNEL_NUM_IN + i)
//   weight_rd_data   weight memory data, one cycle after the strobe
//   valid_weight_out weight beat to the conv core (strobe delayed one cycle)
//   weight_out       weight word, straight from weight_rd_data
//   pxl_en           enables the pixel loop source during STREAM
//   pxl_beat         one pixel beat accepted by the conv core
//   res_valid        one finished output pixel from the channel adder
//   out_ch           index of the pass in progress
//   busy             high whenever the scheduler is not idle
//   pass_done        one-cycle pulse as each pass completes
//   done             one-cycle pulse after the last pass
module conv_1x1_pass_scheduler #(
  parameter int DATA_WIDTH      = 32,
  parameter int CHANNEL_NUM_IN  = 256,
  parameter int CHANNEL_NUM_OUT = 48,
  parameter int IMAGE_SIZE      = 4096,
  parameter int ADDR_WIDTH      = 14,
  localparam int OUT_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  weight_rd_en,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  input  logic [DATA_WIDTH-1:0] weight_rd_data,
  output logic                  valid_weight_out,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  pxl_en,
  input  logic                  pxl_beat,
  input  logic                  res_valid,
  output logic [OUT_W-1:0]      out_ch,
  output logic                  busy,
  output logic                  pass_done,
  output logic                  done
);

  localparam int IDX_W     = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int PXL_TOTAL = IMAGE_SIZE * CHANNEL_NUM_IN;
  localparam int PXL_W     = $clog2(PXL_TOTAL + 1);
  localparam int RES_W     = $clog2(IMAGE_SIZE + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNEL_NUM_IN - 1);
  localparam logic [PXL_W-1:0] PXL_LAST = PXL_W'(PXL_TOTAL - 1);
  localparam logic [RES_W-1:0] RES_FULL = RES_W'(IMAGE_SIZE);
  localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(CHANNEL_NUM_OUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    FINISH
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [PXL_W-1:0]      pxlCnt_q;
  logic [RES_W-1:0]      resCnt_q;
  logic [RES_W-1:0]      resCnt_d;
  logic [OUT_W-1:0]      outCh_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rdEn_q;
  logic                  validWeight_q;
  logic                  pxlEn_q;
  logic                  busy_q;
  logic                  passDone_q;
  logic                  done_q;
  logic                  resAccept;

  // Results count only while a pass is streaming or draining. The count
  // saturates at IMAGE_SIZE so that surplus beats are dropped. DRAIN tests
  // the next-state count, which lets the beat that completes the pass end
  // it in the same cycle.
  always_comb begin
    resAccept = res_valid && ((state_q == STREAM) || (state_q == DRAIN)) &&
                (resCnt_q != RES_FULL);
    resCnt_d  = resCnt_q + RES_W'(resAccept);
  end

  // Main pass FSM with registered outputs. Weight addresses run contiguously
  // across passes, so the next pass's base is the previous last address + 1.
  // No multiplier is needed for that.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      pxlCnt_q      <= '0;
      resCnt_q      <= '0;
      outCh_q       <= '0;
      addr_q        <= '0;
      rdEn_q        <= 1'b0;
      validWeight_q <= 1'b0;
      pxlEn_q       <= 1'b0;
      busy_q        <= 1'b0;
      passDone_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      validWeight_q <= rdEn_q;
      passDone_q    <= 1'b0;
      done_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= LOAD_W;
            idx_q    <= '0;
            pxlCnt_q <= '0;
            resCnt_q <= '0;
            outCh_q  <= '0;
            addr_q   <= '0;
            rdEn_q   <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        LOAD_W: begin
          // The strobe is already high on entry. The last strobe hands over
          // to STREAM, so the final weight beat lands in STREAM's first cycle.
          if (idx_q == IDX_LAST) begin
            rdEn_q  <= 1'b0;
            pxlEn_q <= 1'b1;
            state_q <= STREAM;
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end
        STREAM: begin
          resCnt_q <= resCnt_d;
          if (pxl_beat) begin
            pxlCnt_q <= pxlCnt_q + PXL_W'(1);
            if (pxlCnt_q == PXL_LAST) begin
              pxlEn_q <= 1'b0;
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          resCnt_q <= resCnt_d;
          if (resCnt_d == RES_FULL) begin
            passDone_q <= 1'b1;
            if (outCh_q == OUT_LAST) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              outCh_q  <= outCh_q + OUT_W'(1);
              idx_q    <= '0;
              pxlCnt_q <= '0;
              resCnt_q <= '0;
              addr_q   <= addr_q + ADDR_WIDTH'(1);
              rdEn_q   <= 1'b1;
              state_q  <= LOAD_W;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          outCh_q <= '0;
          addr_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output wiring. Only weight_out is combinational, taken from memory data.
  always_comb begin
    weight_rd_en     = rdEn_q;
    weight_addr      = addr_q;
    valid_weight_out = validWeight_q;
    weight_out       = weight_rd_data;
    pxl_en           = pxlEn_q;
    out_ch           = outCh_q;
    busy             = busy_q;
    pass_done        = passDone_q;
    done             = done_q;
  end

endmodule

// File: tb/tb_conv_1x1_pass_scheduler.sv
// tb_conv_1x1_pass_scheduler
//
// Drives conv_1x1_pass_scheduler with CHANNEL_NUM_IN=4, CHANNEL_NUM_OUT=2 and
// IMAGE_SIZE=3. A one-cycle-latency weight memory returns data = address.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_conv_1x1_pass_scheduler;

  localparam int DW   = 16;
  localparam int CIN  = 4;
  localparam int COUT = 2;
  localparam int IMG  = 3;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          weight_rd_en;
  logic [AW-1:0] weight_addr;
  logic [DW-1:0] weight_rd_data = '0;
  logic          valid_weight_out;
  logic [DW-1:0] weight_out;
  logic          pxl_en;
  logic          pxl_beat = 1'b0;
  logic          res_valid = 1'b0;
  logic [0:0]    out_ch;
  logic          busy;
  logic          pass_done;
  logic          done;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    bit start;
    bit pxlBeat;
    bit resValid;
    bit rdEn;
    int addr;
    bit vwo;
    int wout;
    bit pxlEn;
    bit busy;
    bit passDone;
    bit done;
    int outCh;
  } vec_t;

  vec_t tbl[$];

  conv_1x1_pass_scheduler #(
    .DATA_WIDTH(DW),
    .CHANNEL_NUM_IN(CIN),
    .CHANNEL_NUM_OUT(COUT),
    .IMAGE_SIZE(IMG),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .weight_rd_en(weight_rd_en),
    .weight_addr(weight_addr),
    .weight_rd_data(weight_rd_data),
    .valid_weight_out(valid_weight_out),
    .weight_out(weight_out),
    .pxl_en(pxl_en),
    .pxl_beat(pxl_beat),
    .res_valid(res_valid),
    .out_ch(out_ch),
    .busy(busy),
    .pass_done(pass_done),
    .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Weight memory: one cycle read latency, contents equal to the address.
  always @(posedge clk) weight_rd_data <= DW'(weight_addr);

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "[TB] watchdog");
  end

  // Packs the observable outputs. Address and weight fields are masked when
  // their qualifiers are low.
  function automatic logic [63:0] actOut();
    return 64'({weight_rd_en, (weight_rd_en ? weight_addr : AW'(0)),
                valid_weight_out, (valid_weight_out ? weight_out : DW'(0)),
                pxl_en, busy, pass_done, done, out_ch});
  endfunction

  function automatic logic [63:0] expOut(input vec_t v);
    return 64'({v.rdEn, (v.rdEn ? AW'(v.addr) : AW'(0)),
                v.vwo, (v.vwo ? DW'(v.wout) : DW'(0)),
                v.pxlEn, v.busy, v.passDone, v.done, 1'(v.outCh)});
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit pb, input bit rv);
    start     = s;
    pxl_beat  = pb;
    res_valid = rv;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulseStart();
    applyStimulus(1, 0, 0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitPxlEn(input string name);
    for (int k = 0; k < 60 && pxl_en !== 1'b1; k++) @(negedge clk);
    checkOutput(name, 64'(pxl_en), 64'(1));
  endtask

  task automatic addRow(input bit s, input bit pb, input bit rv, input bit re,
                        input int a, input bit vw, input int wo, input bit pe,
                        input bit bz, input bit pd, input bit dn, input int oc);
    vec_t v;
    v.start = s; v.pxlBeat = pb; v.resValid = rv; v.rdEn = re; v.addr = a;
    v.vwo = vw; v.wout = wo; v.pxlEn = pe; v.busy = bz; v.passDone = pd;
    v.done = dn; v.outCh = oc;
    tbl.push_back(v);
  endtask

  // Cycle-by-cycle expectation of a complete two-pass run with pxl_beat held
  // high and three results in each DRAIN. With restart set, start is also
  // pulsed in LOAD_W and DRAIN, and the expected outputs stay the same.
  task automatic fillRun(input bit restart);
    tbl.delete();
    addRow(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++)
        addRow(restart && p == 0 && i == 1, 1, 0, 1, p * 4 + i, i > 0, p * 4 + i - 1,
               0, 1, p == 1 && i == 0, 0, p);
      for (int s = 0; s < 12; s++)
        addRow(0, 1, 0, 0, 0, s == 0, p * 4 + 3, 1, 1, 0, 0, p);
      for (int d = 0; d < 3; d++)
        addRow(restart && ((p == 0 && d == 2) || (p == 1 && d == 0)), 1, 1,
               0, 0, 0, 0, 0, 1, 0, 0, p);
    end
    addRow(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
    addRow(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic runTable(input string tag);
    foreach (tbl[r]) begin
      applyStimulus(tbl[r].start, tbl[r].pxlBeat, tbl[r].resValid);
      checkOutput($sformatf("%s cycle %0d", tag, r), actOut(), expOut(tbl[r]));
      @(negedge clk);
    end
    applyStimulus(0, 0, 0);
  endtask

  initial begin
    int streamLen;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state, with start held high throughout reset.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    checkOutput("reset outputs", actOut(), 64'(0));
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("start with reset ignored", actOut(), 64'(0));

    // Full run, then the same run with start re-pulsed while busy.
    doReset();
    fillRun(0);
    runTable("fullRun");
    doReset();
    fillRun(1);
    runTable("restartIgnored");

    // Gapped pixels: a beat on every other STREAM cycle.
    doReset();
    pulseStart();
    waitPxlEn("gapped reach STREAM");
    streamLen = 0;
    for (int k = 0; k < 60 && pxl_en === 1'b1; k++) begin
      applyStimulus(0, k[0], 0);
      streamLen++;
      @(negedge clk);
    end
    checkOutput("gapped STREAM length", 64'(streamLen), 64'(24));
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 1, 1);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0);
    checkOutput("gapped pass end", 64'({pass_done, weight_rd_en, weight_addr}),
                64'({1'b1, 1'b1, AW'(4)}));

    // Early results: all three arrive in STREAM, the last one with beat 12.
    doReset();
    pulseStart();
    waitPxlEn("early reach STREAM");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, k == 5 || k == 8 || k == 11);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0);
    checkOutput("early single DRAIN", 64'({pxl_en, busy, pass_done}), 64'({1'b0, 1'b1, 1'b0}));
    @(negedge clk);
    checkOutput("early pass end",
                64'({pass_done, weight_rd_en, weight_addr, out_ch}),
                64'({1'b1, 1'b1, AW'(4), 1'b1}));

    // Four results in DRAIN: the fourth must not count toward pass 1.
    doReset();
    pulseStart();
    waitPxlEn("extra reach STREAM");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1);
      @(negedge clk);
    end
    checkOutput("extra pass1 start",
                64'({pass_done, weight_rd_en, weight_addr}), 64'({1'b1, 1'b1, AW'(4)}));
    @(negedge clk);
    applyStimulus(0, 0, 0);
    waitPxlEn("extra reach pass1 STREAM");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0);
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, 0, 1);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0);
    checkOutput("extra pass1 still draining", 64'({busy, pass_done, done}),
                64'({1'b1, 1'b0, 1'b0}));
    applyStimulus(0, 0, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0);
    checkOutput("extra final pulses", 64'({busy, pass_done, done}), 64'({1'b1, 1'b1, 1'b1}));
    @(negedge clk);
    checkOutput("extra back to idle", actOut(), 64'(0));

    // Reset in pass 1 STREAM after five beats, with start also high.
    doReset();
    pulseStart();
    waitPxlEn("midReset reach STREAM");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 0);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1);
      @(negedge clk);
    end
    applyStimulus(0, 0, 0);
    waitPxlEn("midReset reach pass1 STREAM");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0);
      @(negedge clk);
    end
    applyStimulus(1, 1, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midReset outputs", actOut(), 64'(0));
    reset = 1'b0;
    applyStimulus(0, 0, 0);
    @(negedge clk);
    checkOutput("midReset stays idle", actOut(), 64'(0));
    pulseStart();
    checkOutput("midReset restart",
                64'({weight_rd_en, weight_addr, out_ch, busy}),
                64'({1'b1, AW'(0), 1'b0, 1'b1}));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/conv_1x1_pass_scheduler.md
CONV_1X1_PASS_SCHEDULER -- requirements
Module: conv_1x1_pass_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 32: pixel/weight word width.
REQ-002 Parameter CHANNEL_NUM_IN, default 256: input channels, i.e. weights per output-channel pass.
REQ-003 Parameter CHANNEL_NUM_OUT, default 48: output channels, i.e. number of passes.
REQ-004 Parameter IMAGE_SIZE, default 4096: pixels per channel plane.
REQ-005 Parameter ADDR_WIDTH, default 14: weight memory address width; must be >= clog2(CHANNEL_NUM_IN*CHANNEL_NUM_OUT).
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high.
REQ-008 start  input  1  one-cycle request to run all passes; ignored unless idle.
REQ-009 weight_rd_en  output  1  weight memory read strobe.
REQ-010 weight_addr  output  ADDR_WIDTH  weight memory address.
REQ-011 weight_rd_data  input  DATA_WIDTH  weight memory data, valid exactly 1 cycle after weight_rd_en.
REQ-012 valid_weight_out  output  1  weight beat to the conv core's weight port.
REQ-013 weight_out  output  DATA_WIDTH  weight word; equals weight_rd_data.
REQ-014 pxl_en  output  1  enables the pixel loop source for the current pass.
REQ-015 pxl_beat  input  1  one pixel beat accepted by the conv core.
REQ-016 res_valid  input  1  one finished output pixel from the channel adder.
REQ-017 out_ch  output  clog2(CHANNEL_NUM_OUT)  index of the current pass.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 pass_done  output  1  one-cycle pulse at the end of each pass.
REQ-020 done  output  1  one-cycle pulse after the last pass.

Function
REQ-021 FSM states: IDLE, LOAD_W, STREAM, DRAIN, FINISH.
REQ-022 IDLE -> LOAD_W on start; out_ch and all counters cleared to 0 on that edge.
REQ-023 LOAD_W: weight_rd_en high for exactly CHANNEL_NUM_IN consecutive cycles; weight_addr = out_ch*CHANNEL_NUM_IN + i, where i = 0..CHANNEL_NUM_IN-1.
REQ-024 valid_weight_out is weight_rd_en delayed by 1 cycle; weight_out is combinational from weight_rd_data.
REQ-025 LOAD_W -> STREAM in the cycle after the last read strobe, so the final weight beat coincides with the first STREAM cycle.
REQ-026 STREAM: pxl_en high; count pxl_beat up to IMAGE_SIZE*CHANNEL_NUM_IN. On the final beat, deassert pxl_en in the next cycle and go to DRAIN.
REQ-027 pxl_beat outside STREAM is ignored and not counted.
REQ-028 res_valid is counted in STREAM and DRAIN. Count width is clog2(IMAGE_SIZE+1); beats beyond IMAGE_SIZE are ignored.
REQ-029 Leave DRAIN when the result count reaches IMAGE_SIZE, including a count completed during STREAM.
- Exit cycle: pass_done pulses 1 cycle.
- If out_ch == CHANNEL_NUM_OUT-1: go to FINISH.
- Otherwise: out_ch increments, counters clear, go to LOAD_W.
REQ-030 FINISH: done pulses 1 cycle; next state IDLE; out_ch returns to 0.
REQ-031 start while busy is ignored and does not restart or extend the run.
REQ-032 A simultaneous final pxl_beat and final res_valid in STREAM are both counted. The FSM then passes through DRAIN for one cycle and exits at that cycle.
REQ-033 Address arithmetic is unsigned and never wraps; the maximum address is CHANNEL_NUM_IN*CHANNEL_NUM_OUT-1.
REQ-034 With CHANNEL_NUM_OUT=1, the first pass ends in FINISH.

Reset
REQ-035 On reset (any state, including mid-pass), on the next edge:
- FSM goes to IDLE.
- Counters and out_ch clear to 0.
- weight_rd_en, valid_weight_out, pxl_en, busy, pass_done and done are 0.
- weight_addr is 0.
REQ-036 start asserted together with reset is ignored.

Verification (bench params: CHANNEL_NUM_IN=4, CHANNEL_NUM_OUT=2, IMAGE_SIZE=3)
REQ-037 Full run:
- Stimulus: start pulse; memory returns data = addr; pxl_beat held high; 3 res_valid pulses after each STREAM.
- Required: addresses 0-3, then 4-7; weight_out 0-3, then 4-7, each valid 1 cycle after its strobe.
- Required: pxl_en high 12 cycles per pass; pass_done pulses twice; done pulses once; busy falls after done.
REQ-038 Gapped pixels: pxl_beat toggles every other cycle -> STREAM lasts 24 cycles; exactly 12 beats counted.
REQ-039 Early results: all 3 res_valid arrive during STREAM, the last together with the 12th pxl_beat -> one DRAIN cycle, then pass_done.
REQ-040 start re-pulsed during LOAD_W and during DRAIN -> no change to addresses, counts or pulse counts.
REQ-041 Reset in pass 1 STREAM after 5 beats -> next cycle all outputs 0 and IDLE. A new start restarts at addr 0 with out_ch=0.
REQ-042 Extra res_valid (4 pulses) in DRAIN -> the 4th is ignored; pass 1 still begins at addr 4.
